// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: funct3 access codes, writeback error codes, FSM states
// and the decode helpers used when an op is accepted.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } lsu_state_e;

  // Stores only have SB/SH/SW; loads additionally allow the unsigned byte/half forms.
  function automatic logic f3_illegal(input logic [2:0] funct3, input logic is_store);
    logic bad;
    if (is_store) begin
      bad = (funct3 >= 3'b011);
    end else begin
      bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    return bad;
  endfunction

  // funct3[1:0] carries the access size for every legal encoding.
  function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] alo);
    logic bad;
    case (funct3[1:0])
      2'b01:   bad = alo[0];
      2'b10:   bad = (alo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering between the 32-bit data bus and the core: byte enables and
// replicated store data on the way out, lane select plus sign/zero extension on the way back.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  alo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift;

  assign rshift = rdata_i >> {alo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << alo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << alo_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  always_comb begin
    rdata_o = rdata_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_BU:   rdata_o = {24'h000000, rshift[7:0]};
      F3_HU:   rdata_o = {16'h0000, rshift[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one op from execute, runs a req/ack data-bus
// access with a timeout, and returns extended load data plus an error code to writeback.
//
//   state  | meaning
//   IDLE   | ex_ready high, waiting for an op from execute
//   REQ    | mem_req held, waiting for mem_ack or timeout
//   RESP   | one-cycle wb_valid pulse carrying wb_data/wb_err
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              ex_memRW_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic [1:0]        wb_err_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [2:0]        funct3_q;
  logic [1:0]        alo_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       wb_data_q;
  lsu_err_e          wb_err_q;

  logic              in_idle;
  logic              accept;
  logic              ack_hit;
  logic              tmo_hit;
  lsu_err_e          acc_err;
  logic [2:0]        al_funct3;
  logic [1:0]        al_alo;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = in_idle && ex_valid_i;
  assign ack_hit = (state_q == S_REQ) && mem_ack_i;
  assign tmo_hit = (state_q == S_REQ) && !mem_ack_i && (timer_q == TMO_LAST);

  // Illegal encodings take priority over misalignment.
  always_comb begin
    acc_err = ERR_OK;
    if (f3_illegal(ex_funct3_i, ex_memRW_i)) begin
      acc_err = ERR_ILLEGAL;
    end else if (f3_misaligned(ex_funct3_i, ex_addr_i[1:0])) begin
      acc_err = ERR_MISALIGN;
    end
  end

  // One aligner serves both directions: live execute inputs at accept, latched op during REQ.
  assign al_funct3 = in_idle ? ex_funct3_i     : funct3_q;
  assign al_alo    = in_idle ? ex_addr_i[1:0] : alo_q;

  lsu_lane_align u_align (
    .funct3_i (al_funct3),
    .alo_i    (al_alo),
    .wdata_i  (ex_wdata_i),
    .rdata_i  (mem_rdata_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          timer_d = 8'd0;
          state_d = (acc_err == ERR_OK) ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (ack_hit || tmo_hit) begin
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      timer_q     <= 8'd0;
      funct3_q    <= 3'b000;
      alo_q       <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      wb_data_q   <= 32'h0;
      wb_err_q    <= ERR_OK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (accept) begin
        funct3_q <= ex_funct3_i;
        alo_q    <= ex_addr_i[1:0];
        if (acc_err == ERR_OK) begin
          mem_we_q    <= ex_memRW_i;
          mem_addr_q  <= {ex_addr_i[ADDR_W-1:2], 2'b00};
          mem_be_q    <= al_be;
          mem_wdata_q <= al_wdata;
        end else begin
          wb_err_q  <= acc_err;
          wb_data_q <= 32'h0;
        end
      end
      if (ack_hit) begin
        wb_err_q  <= ERR_OK;
        wb_data_q <= mem_we_q ? 32'h0 : al_rdata;
      end else if (tmo_hit) begin
        wb_err_q  <= ERR_TIMEOUT;
        wb_data_q <= 32'h0;
      end
    end
  end

  assign ex_ready_o  = in_idle;
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_valid_o  = (state_q == S_RESP);
  assign wb_data_o   = wb_data_q;
  assign wb_err_o    = wb_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: hand-computed vectors for loads, stores,
// error paths, timeout, back-to-back operation and reset during a bus request.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_funct3;
  logic        ex_memRW;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [1:0]  wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .ex_valid_i  (ex_valid),
    .ex_ready_o  (ex_ready),
    .ex_addr_i   (ex_addr),
    .ex_wdata_i  (ex_wdata),
    .ex_funct3_i (ex_funct3),
    .ex_memRW_i  (ex_memRW),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .wb_valid_o  (wb_valid),
    .wb_data_o   (wb_data),
    .wb_err_o    (wb_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one op for a single accept edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] f3, input logic we, input logic [31:0] a, input logic [31:0] d);
    ex_valid  = 1'b1;
    ex_funct3 = f3;
    ex_memRW  = we;
    ex_addr   = a;
    ex_wdata  = d;
    tick();
    ex_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_ex_ready: got %b exp 1", ex_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rst_mem_be: got %b exp 0000", mem_be); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h exp 0", wb_data); end
    checks++; if (wb_err !== 2'b00) begin errors++; $display("FAIL rst_wb_err: got %b exp 00", wb_err); end
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(f3, 1'b0, a, 32'h0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s_req: got %b exp 1", nm, mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s_we: got %b exp 0", nm, mem_we); end
    checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL %s_addr: got %h exp %h", nm, mem_addr, exp_addr); end
    checks++; if (mem_be !== exp_be) begin errors++; $display("FAIL %s_be: got %b exp %b", nm, mem_be, exp_be); end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s_wbv: got %b exp 1", nm, wb_valid); end
    checks++; if (wb_data !== exp_data) begin errors++; $display("FAIL %s_data: got %h exp %h", nm, wb_data, exp_data); end
    checks++; if (wb_err !== 2'b00) begin errors++; $display("FAIL %s_err: got %b exp 00", nm, wb_err); end
    tick();
    checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL %s_done: got wbv=%b rdy=%b exp 0/1", nm, wb_valid, ex_ready); end
  endtask

  task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    issue(f3, 1'b1, a, d);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL %s_req_we: got %b%b exp 11", nm, mem_req, mem_we); end
    checks++; if (mem_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr: got %h exp %h", nm, mem_addr, {a[31:2], 2'b00}); end
    checks++; if (mem_be !== exp_be) begin errors++; $display("FAIL %s_be: got %b exp %b", nm, mem_be, exp_be); end
    checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata: got %h exp %h", nm, mem_wdata, exp_wdata); end
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack   = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_err !== 2'b00) begin errors++; $display("FAIL %s_wb: got v=%b d=%h e=%b exp 1/0/00", nm, wb_valid, wb_data, wb_err); end
    tick();
  endtask

  task automatic test_error(input string nm, input logic [2:0] f3, input logic we, input logic [31:0] a,
                            input logic [1:0] exp_err);
    issue(f3, we, a, 32'h1234_5678);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_noreq: got %b exp 0", nm, mem_req); end
    checks++; if (wb_valid !== 1'b1 || ex_ready !== 1'b0) begin errors++; $display("FAIL %s_wbv: got v=%b rdy=%b exp 1/0", nm, wb_valid, ex_ready); end
    checks++; if (wb_err !== exp_err || wb_data !== 32'h0) begin errors++; $display("FAIL %s_err: got e=%b d=%h exp %b/0", nm, wb_err, wb_data, exp_err); end
    tick();
    checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL %s_after: got v=%b req=%b exp 0/0", nm, wb_valid, mem_req); end
  endtask

  task automatic test_timeout();
    int n;
    int stray;
    n = 0;
    issue(3'b101, 1'b0, 32'h0000_4000, 32'h0);
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL tmo_req_cycles: got %0d exp 16", n); end
    checks++; if (wb_valid !== 1'b1 || wb_err !== 2'b10 || wb_data !== 32'h0) begin errors++; $display("FAIL tmo_wb: got v=%b e=%b d=%h exp 1/10/0", wb_valid, wb_err, wb_data); end
    tick();
    stray = 0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_valid !== 1'b0 || mem_req !== 1'b0) stray++;
    end
    mem_ack = 1'b0;
    checks++; if (stray != 0) begin errors++; $display("FAIL tmo_stray_ack: got %0d reactive cycles exp 0", stray); end
    checks++; if (wb_err !== 2'b10) begin errors++; $display("FAIL tmo_err_hold: got %b exp 10", wb_err); end
  endtask

  task automatic test_back_to_back();
    issue(3'b010, 1'b0, 32'h0000_5000, 32'h0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req1: got %b exp 1", mem_req); end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    ex_valid  = 1'b1;
    ex_funct3 = 3'b100;
    ex_memRW  = 1'b0;
    ex_addr   = 32'h0000_6001;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0000_AB00;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_wb1: got v=%b d=%h exp 1/deadbeef", wb_valid, wb_data); end
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL b2b_resp_ready: got %b exp 0", ex_ready); end
    tick();
    checks++; if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle: got rdy=%b req=%b exp 1/0", ex_ready, mem_req); end
    tick();
    ex_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6000 || mem_be !== 4'b0010) begin errors++; $display("FAIL b2b_req2: got req=%b a=%h be=%b exp 1/00006000/0010", mem_req, mem_addr, mem_be); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00AB) begin errors++; $display("FAIL b2b_wb2: got v=%b d=%h exp 1/000000ab", wb_valid, wb_data); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    issue(3'b010, 1'b0, 32'h0000_7000, 32'h0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b exp 1", mem_req); end
    reset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got req=%b rdy=%b v=%b exp 0/1/0", mem_req, ex_ready, wb_valid); end
    checks++; if (mem_addr !== 32'h0 || mem_be !== 4'b0000) begin errors++; $display("FAIL rmid_bus: got a=%h be=%b exp 0/0000", mem_addr, mem_be); end
    reset   = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb_valid === 1'b1) pulses++;
    end
    mem_ack = 1'b0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_wb: got %0d pulses exp 0", pulses); end
  endtask

  initial begin
    reset     = 1'b1;
    ex_valid  = 1'b0;
    ex_addr   = 32'h0;
    ex_wdata  = 32'h0;
    ex_funct3 = 3'b000;
    ex_memRW  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    test_reset();
    test_load("lb", 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    test_load("lh", 3'b001, 32'h0000_8002, 32'h8001_7FFF, 32'h0000_8000, 4'b1100, 32'hFFFF_8001);
    test_load("lhu", 3'b101, 32'h0000_8002, 32'h8001_7FFF, 32'h0000_8000, 4'b1100, 32'h0000_8001);
    test_load("lbu", 3'b100, 32'h0000_8001, 32'h0000_F200, 32'h0000_8000, 4'b0010, 32'h0000_00F2);
    test_load("lw", 3'b010, 32'h0000_8004, 32'hCAFE_F00D, 32'h0000_8004, 4'b1111, 32'hCAFE_F00D);
    test_store("sh", 3'b001, 32'h0000_2002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store("sb", 3'b000, 32'h0000_9001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    test_store("sw", 3'b010, 32'h0000_9008, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    test_error("lw_misal", 3'b010, 1'b0, 32'h0000_3001, 2'b01);
    test_error("sh_misal", 3'b001, 1'b1, 32'h0000_3003, 2'b01);
    test_error("ld_f3_011", 3'b011, 1'b0, 32'h0000_3000, 2'b11);
    test_error("st_f3_101_prio", 3'b101, 1'b1, 32'h0000_3001, 2'b11);
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
